// File: rtl/data_mem_responder_if.sv
// MEM-stage data memory bus: the pipeline drives requests, the responder returns data and hold.
// stall_c is combinational so the request cycle itself can be held.
interface data_mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  byte_sel;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall_c;
    logic        ready;

    modport master (
        output mem_read, mem_write, byte_sel, address, write_data,
        input  read_data, stall_c, ready
    );

    modport slave (
        input  mem_read, mem_write, byte_sel, address, write_data,
        output read_data, stall_c, ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state data memory for the MEM stage: one latched load/store at a time over a
// little-endian word array, holding the pipeline until the access completes.
module data_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    data_mem_responder_if.slave  io_mem
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [CW-1:0]   r_cnt;
    logic            r_ready;
    logic [31:0]     r_read_data;
    logic            r_rd;
    logic            r_wr;
    logic [1:0]      r_sel;
    logic [AW-1:0]   r_idx;
    logic [1:0]      r_off;
    logic [31:0]     r_wdata;
    logic [31:0]     r_mem [DEPTH];

    logic            w_req;
    logic            w_accept;
    logic            w_stall_c;
    logic            w_cnt_load;
    logic            w_cnt_dec;
    logic            w_ready_d;
    logic            w_mem_we;
    logic            w_rdata_load;
    logic [31:0]     w_old;
    logic [3:0]      w_be;
    logic [31:0]     w_wrep;
    logic [31:0]     w_mask;
    logic [31:0]     w_merged;
    logic [15:0]     w_half;
    logic [7:0]      w_byte;
    logic [31:0]     w_rd_ext;
    logic            w_unused;

    assign w_req = io_mem.mem_read | io_mem.mem_write;

    // Address bits above the word index are ignored: accesses wrap modulo DEPTH words.
    assign w_unused = ^io_mem.address[31:AW+2];

    // State register
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next = (WAIT_CYCLES > 0) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        w_accept     = 1'b0;
        w_stall_c    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_mem_we     = 1'b0;
        w_rdata_load = 1'b0;
        w_ready_d    = (w_next == ST_DONE);
        case (r_state)
            ST_IDLE: begin
                w_accept   = w_req;
                w_stall_c  = w_req;
                w_cnt_load = w_req && (WAIT_CYCLES > 0);
            end
            ST_BUSY: begin
                w_stall_c = 1'b1;
                w_cnt_dec = (r_cnt != '0);
            end
            ST_DONE: begin
                w_mem_we     = r_wr;
                w_rdata_load = r_rd;
            end
            default: begin
                w_stall_c = 1'b0;
            end
        endcase
    end

    // Request latch, wait counter and load result
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_read_data <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_sel       <= '0;
            r_idx       <= '0;
            r_off       <= '0;
            r_wdata     <= '0;
        end else begin
            r_ready <= w_ready_d;
            if (w_accept) begin
                r_rd    <= io_mem.mem_read;
                r_wr    <= io_mem.mem_write;
                r_sel   <= io_mem.byte_sel;
                r_idx   <= io_mem.address[AW+1:2];
                r_off   <= io_mem.address[1:0];
                r_wdata <= io_mem.write_data;
            end
            if (w_cnt_load) begin
                r_cnt <= CNT_LOAD;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_rdata_load) begin
                r_read_data <= w_rd_ext;
            end
        end
    end

    assign w_old = r_mem[r_idx];

    // Store lane enables with the data replicated across every candidate lane
    always_comb begin
        w_be   = 4'h0;
        w_wrep = '0;
        case (r_sel)
            2'b00: begin
                w_be   = 4'hF;
                w_wrep = r_wdata;
            end
            2'b01: begin
                w_be   = r_off[1] ? 4'hC : 4'h3;
                w_wrep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b0001 << r_off;
                w_wrep = {4{r_wdata[7:0]}};
            end
        endcase
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < 4; i++) begin
            w_mask[8*i +: 8] = {8{w_be[i]}};
        end
    end

    assign w_merged = (w_old & ~w_mask) | (w_wrep & w_mask);

    // Load extraction from pre-write contents
    assign w_half = r_off[1] ? w_old[31:16] : w_old[15:0];
    assign w_byte = w_old[{r_off, 3'b000} +: 8];

    always_comb begin
        w_rd_ext = w_old;
        case (r_sel)
            2'b00:   w_rd_ext = w_old;
            2'b01:   w_rd_ext = {{16{w_half[15]}}, w_half};
            2'b10:   w_rd_ext = {{24{w_byte[7]}}, w_byte};
            default: w_rd_ext = {24'h000000, w_byte};
        endcase
    end

    // Array is not reset; a reset landing in DONE must still suppress the write.
    always_ff @(posedge i_clock) begin
        if (i_reset_n && w_mem_we) begin
            r_mem[r_idx] <= w_merged;
        end
    end

    assign io_mem.read_data = r_read_data;
    assign io_mem.stall_c   = w_stall_c;
    assign io_mem.ready     = r_ready;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference memory with request/done timing,
// compared every cycle, plus directed loads pinned to literal values.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned W     = 2;
    localparam int unsigned NB    = 4 * DEPTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .io_mem    (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte array, one outstanding request, completes W+1 cycles after acceptance
    logic [7:0]  m_bytes [NB];
    int          cyc      = 0;
    bit          m_valid  = 1'b0;
    bit          m_active = 1'b0;
    int          m_done   = 0;
    logic        m_rd, m_wr;
    logic [1:0]  m_sel;
    logic [31:0] m_addr, m_wd;
    logic [31:0] m_rdata  = '0;

    function automatic logic [31:0] mload(input logic [31:0] addr, input logic [1:0] sel);
        int ba;
        int base;
        logic [15:0] h;
        ba = int'(addr % NB);
        case (sel)
            2'b00: begin
                base = ba - (ba % 4);
                return {m_bytes[base+3], m_bytes[base+2], m_bytes[base+1], m_bytes[base]};
            end
            2'b01: begin
                base = ba - (ba % 2);
                h = {m_bytes[base+1], m_bytes[base]};
                return {{16{h[15]}}, h};
            end
            2'b10:   return {{24{m_bytes[ba][7]}}, m_bytes[ba]};
            default: return {24'h000000, m_bytes[ba]};
        endcase
    endfunction

    task automatic mstore(input logic [31:0] addr, input logic [1:0] sel, input logic [31:0] wd);
        int ba;
        int base;
        ba = int'(addr % NB);
        case (sel)
            2'b00: begin
                base = ba - (ba % 4);
                for (int k = 0; k < 4; k++) m_bytes[base+k] = wd[8*k +: 8];
            end
            2'b01: begin
                base = ba - (ba % 2);
                m_bytes[base]   = wd[7:0];
                m_bytes[base+1] = wd[15:8];
            end
            default: m_bytes[ba] = wd[7:0];
        endcase
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_rdata  = '0;
            m_valid  = 1'b1;
        end else if (m_active && cyc == m_done) begin
            if (m_rd) m_rdata = mload(m_addr, m_sel);
            if (m_wr) mstore(m_addr, m_sel, m_wd);
            m_active = 1'b0;
        end
        cyc++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            if (rst_n && !m_active && (bus.mem_read || bus.mem_write)) begin
                m_active = 1'b1;
                m_done   = cyc + int'(W) + 1;
                m_rd     = bus.mem_read;
                m_wr     = bus.mem_write;
                m_sel    = bus.byte_sel;
                m_addr   = bus.address;
                m_wd     = bus.write_data;
            end
            chk("stall", {31'b0, bus.stall_c}, {31'b0, (m_active && cyc < m_done)});
            chk("ready", {31'b0, bus.ready},   {31'b0, (m_active && cyc == m_done)});
            chk("read_data", bus.read_data, m_rdata);
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [1:0] sel,
                          input logic [31:0] addr, input logic [31:0] wd, input bit scramble,
                          output int stall_cnt, output int ready_cnt, output logic [31:0] rdata);
        @(posedge clk); #1;
        bus.mem_read = rd; bus.mem_write = wr; bus.byte_sel = sel;
        bus.address = addr; bus.write_data = wd;
        stall_cnt = 0;
        ready_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.stall_c) stall_cnt++;
            if (bus.ready) begin
                ready_cnt++;
                break;
            end
            if (scramble && i == 0) begin
                @(posedge clk); #1;
                bus.address = 32'h0000_0FF0; bus.write_data = 32'h5555_5555; bus.byte_sel = 2'b00;
            end
        end
        if (ready_cnt == 0) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        @(negedge clk);
        if (bus.ready) ready_cnt++;
        rdata = bus.read_data;
    endtask

    int          sc, rc;
    logic [31:0] rd;

    initial begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.byte_sel = 2'b00;
        bus.address = '0; bus.write_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_read_data", bus.read_data, 32'h0);
        chk("reset_stall", {31'b0, bus.stall_c}, 32'h0);
        chk("reset_ready", {31'b0, bus.ready}, 32'h0);

        access(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 1'b0, sc, rc, rd);
        chk("store_stall_cycles", 32'(sc), 32'(W + 1));
        chk("store_ready_pulses", 32'(rc), 32'd1);
        chk("store_keeps_rdata", rd, 32'h0);
        access(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, sc, rc, rd);
        chk("load_word", rd, 32'hDEADBEEF);

        access(1'b0, 1'b1, 2'b10, 32'h11, 32'h0000007F, 1'b0, sc, rc, rd);
        access(1'b0, 1'b1, 2'b01, 32'h12, 32'h00008001, 1'b0, sc, rc, rd);
        access(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, sc, rc, rd);
        chk("load_merged_word", rd, 32'h80017FEF);
        access(1'b1, 1'b0, 2'b10, 32'h12, 32'h0, 1'b0, sc, rc, rd);
        chk("load_byte_12_sx", rd, 32'h00000001);
        access(1'b1, 1'b0, 2'b01, 32'h12, 32'h0, 1'b0, sc, rc, rd);
        chk("load_half_12_sx", rd, 32'hFFFF8001);
        access(1'b1, 1'b0, 2'b11, 32'h13, 32'h0, 1'b0, sc, rc, rd);
        chk("load_byte_13_zx", rd, 32'h00000080);
        access(1'b1, 1'b0, 2'b10, 32'h13, 32'h0, 1'b0, sc, rc, rd);
        chk("load_byte_13_sx", rd, 32'hFFFFFF80);

        access(1'b0, 1'b1, 2'b00, 32'h1003, 32'h12345678, 1'b0, sc, rc, rd);
        access(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, sc, rc, rd);
        chk("wrap_index0", rd, 32'h12345678);

        access(1'b1, 1'b1, 2'b00, 32'h10, 32'h0, 1'b0, sc, rc, rd);
        chk("rw_pre_write", rd, 32'h80017FEF);
        access(1'b1, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0, sc, rc, rd);
        chk("rw_post_write", rd, 32'h0);

        access(1'b0, 1'b1, 2'b00, 32'h40, 32'hCAFEF00D, 1'b1, sc, rc, rd);
        access(1'b1, 1'b0, 2'b00, 32'h40, 32'h0, 1'b0, sc, rc, rd);
        chk("latched_address", rd, 32'hCAFEF00D);

        // Reset lands in the first BUSY cycle of a store
        access(1'b0, 1'b1, 2'b00, 32'h20, 32'h11223344, 1'b0, sc, rc, rd);
        @(posedge clk); #1;
        bus.mem_write = 1'b1; bus.byte_sel = 2'b00; bus.address = 32'h20; bus.write_data = 32'hAAAAAAAA;
        @(negedge clk);
        chk("abort_req_stall", {31'b0, bus.stall_c}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0; bus.mem_write = 1'b0;
        @(negedge clk);
        chk("abort_busy_stall", {31'b0, bus.stall_c}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_stall_low", {31'b0, bus.stall_c}, 32'h0);
        chk("abort_ready_low", {31'b0, bus.ready}, 32'h0);
        access(1'b1, 1'b0, 2'b00, 32'h20, 32'h0, 1'b0, sc, rc, rd);
        chk("abort_no_write", rd, 32'h11223344);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
